// File: rtl/mem_arb_pkg.sv
// Shared types and constants for the memory port arbiter.
// Holds the FSM state encoding, the owner codes and the default aging threshold.
package mem_arb_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        I_ACC = 2'd1,
        D_ACC = 2'd2,
        DONE  = 2'd3
    } arb_state_t;

    localparam logic [1:0] OWN_NONE = 2'b00;
    localparam logic [1:0] OWN_I    = 2'b01;
    localparam logic [1:0] OWN_D    = 2'b10;

    localparam int AGE_LIMIT_DEF = 8;

endpackage

// File: rtl/arb_age_counter.sv
// Saturating wait counter for the instruction side; sat tells the arbiter
// that I has starved long enough to take priority over D.
module arb_age_counter
    import mem_arb_pkg::*;
#(
    parameter int LIMIT = AGE_LIMIT_DEF
) (
    input  logic clk,
    input  logic rst,
    input  logic inc,
    input  logic clr,
    output logic sat
);

    localparam int CW = $clog2(LIMIT + 1);
    localparam logic [CW-1:0] LIM = CW'(LIMIT);

    logic [CW-1:0] cnt;

    // clear wins over increment so a grant always restarts the wait count
    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            cnt <= '0;
        else if (clr)
            cnt <= '0;
        else if (inc && !sat)
            cnt <= cnt + 1'b1;
    end

    assign sat = (cnt == LIM);

endmodule

// File: rtl/mem_port_arbiter.sv
// Two-port (instruction fetch / data cache) arbiter onto a single memory port.
// Define MEM_ARB_AGING_EN to let a starved I side override the default D priority.
module mem_port_arbiter
    import mem_arb_pkg::*;
#(
    parameter int WIDTH     = 32,
    parameter int AGE_LIMIT = AGE_LIMIT_DEF
) (
    input  logic             CLK,
    input  logic             Reset,
    input  logic             i_req,
    input  logic [WIDTH-1:0] i_addr,
    output logic [WIDTH-1:0] i_rdata,
    output logic             i_ack,
    input  logic             d_req,
    input  logic             d_we,
    input  logic [WIDTH-1:0] d_addr,
    input  logic [WIDTH-1:0] d_wdata,
    output logic [WIDTH-1:0] d_rdata,
    output logic             d_ack,
    output logic             mem_req,
    output logic             mem_we,
    output logic [WIDTH-1:0] mem_addr,
    output logic [WIDTH-1:0] mem_wdata,
    input  logic [WIDTH-1:0] mem_rdata,
    input  logic             mem_ready,
    output logic [1:0]       owner
);

    arb_state_t       state, next_state;
    logic             grant_i, grant_d;
    logic             in_acc;
    logic             age_sat;
    logic             lat_d;
    logic             lat_we;
    logic [WIDTH-1:0] lat_addr;
    logic [WIDTH-1:0] lat_wdata;

    if (AGE_LIMIT < 1) begin : g_bad_age_limit
        $error("AGE_LIMIT must be at least 1");
    end

`ifdef MEM_ARB_AGING_EN
    arb_age_counter #(
        .LIMIT(AGE_LIMIT)
    ) u_age (
        .clk(CLK),
        .rst(Reset),
        .inc(i_req && (owner != OWN_I)),
        .clr(grant_i),
        .sat(age_sat)
    );
`else
    assign age_sat = 1'b0;
`endif

    assign in_acc = (state == I_ACC) || (state == D_ACC);

    always_comb begin
        next_state = state;
        grant_i    = 1'b0;
        grant_d    = 1'b0;
        case (state)
            IDLE: begin
                // D normally wins a tie; a saturated age count hands it to I
                if (i_req && (!d_req || age_sat)) begin
                    grant_i    = 1'b1;
                    next_state = I_ACC;
                end else if (d_req) begin
                    grant_d    = 1'b1;
                    next_state = D_ACC;
                end
            end
            I_ACC, D_ACC: begin
                if (mem_ready)
                    next_state = DONE;
            end
            DONE: next_state = IDLE;
            default: next_state = IDLE;
        endcase
    end

    always_ff @(posedge CLK or posedge Reset) begin
        if (Reset) begin
            state     <= IDLE;
            lat_d     <= 1'b0;
            lat_we    <= 1'b0;
            lat_addr  <= '0;
            lat_wdata <= '0;
            i_rdata   <= '0;
            d_rdata   <= '0;
        end else begin
            state <= next_state;
            if (grant_i) begin
                lat_d     <= 1'b0;
                lat_we    <= 1'b0;
                lat_addr  <= i_addr;
                lat_wdata <= '0;
            end else if (grant_d) begin
                lat_d     <= 1'b1;
                lat_we    <= d_we;
                lat_addr  <= d_addr;
                lat_wdata <= d_wdata;
            end
            if (in_acc && mem_ready && !lat_we) begin
                if (lat_d)
                    d_rdata <= mem_rdata;
                else
                    i_rdata <= mem_rdata;
            end
        end
    end

    // Decoded from state so that reset drops the port without waiting for a clock
    assign mem_req   = in_acc;
    assign mem_we    = in_acc && lat_we;
    assign mem_addr  = lat_addr;
    assign mem_wdata = lat_wdata;
    assign i_ack     = (state == DONE) && !lat_d;
    assign d_ack     = (state == DONE) && lat_d;

    always_comb begin
        owner = OWN_NONE;
        case (state)
            I_ACC:   owner = OWN_I;
            D_ACC:   owner = OWN_D;
            DONE:    owner = lat_d ? OWN_D : OWN_I;
            default: owner = OWN_NONE;
        endcase
    end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Scoreboard bench for mem_port_arbiter: directed transfers push expected memory
// requests and acks; a negedge monitor pops and compares them as the DUT presents them.
module tb_mem_port_arbiter;

    logic        CLK = 1'b0;
    logic        Reset;
    logic        i_req, d_req, d_we, mem_ready;
    logic [31:0] i_addr, d_addr, d_wdata, mem_rdata;
    logic [31:0] i_rdata, d_rdata, mem_addr, mem_wdata;
    logic        i_ack, d_ack, mem_req, mem_we;
    logic [1:0]  owner;

    int checks   = 0;
    int failures = 0;

    typedef struct {
        logic        we;
        logic [31:0] addr;
        logic [31:0] wdata;
    } mem_exp_t;

    typedef struct {
        logic        is_d;
        logic [31:0] rdata;
    } ack_exp_t;

    mem_exp_t mem_q[$];
    ack_exp_t ack_q[$];

    mem_port_arbiter #(.WIDTH(32), .AGE_LIMIT(8)) dut (
        .CLK(CLK), .Reset(Reset),
        .i_req(i_req), .i_addr(i_addr), .i_rdata(i_rdata), .i_ack(i_ack),
        .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata),
        .d_rdata(d_rdata), .d_ack(d_ack),
        .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr),
        .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .mem_ready(mem_ready),
        .owner(owner)
    );

    always #5 CLK = ~CLK;

    function automatic void chk(string name, logic [31:0] got, logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%h exp=%h", name, got, exp);
        end
    endfunction

    task automatic step();
        @(posedge CLK);
        #1;
    endtask

    task automatic push_exp(input bit is_d, input bit we, input logic [31:0] addr,
                            input logic [31:0] wdata, input logic [31:0] ack_rdata);
        mem_exp_t m;
        ack_exp_t a;
        m.we = we; m.addr = addr; m.wdata = wdata;
        a.is_d = is_d; a.rdata = ack_rdata;
        mem_q.push_back(m);
        ack_q.push_back(a);
    endtask

    // Called in the first access cycle; returns in the DONE cycle
    task automatic serve(input bit is_d, input int lat, input logic [31:0] rdata);
        chk("mem_req_on", {31'd0, mem_req}, 32'd1);
        chk("owner_acc", {30'd0, owner}, is_d ? 32'd2 : 32'd1);
        for (int k = 0; k < lat; k++) begin
            step();
            chk("mem_req_hold", {31'd0, mem_req}, 32'd1);
        end
        mem_ready = 1'b1;
        mem_rdata = rdata;
        step();
        mem_ready = 1'b0;
        mem_rdata = 32'hF00DCAFE;
        chk("ack_latency", {31'd0, is_d ? d_ack : i_ack}, 32'd1);
        chk("mem_req_done", {31'd0, mem_req}, 32'd0);
        chk("owner_done", {30'd0, owner}, is_d ? 32'd2 : 32'd1);
    endtask

    // Monitor: compares memory request fields and acks against the scoreboard
    initial begin
        logic     req_q;
        mem_exp_t cur;
        mem_exp_t m;
        ack_exp_t a;
        req_q = 1'b0;
        cur.we = 1'b0; cur.addr = '0; cur.wdata = '0;
        forever begin
            @(negedge CLK);
            if (mem_req && !req_q) begin
                if (mem_q.size() == 0) begin
                    chk("mem_req_unexpected", 32'd1, 32'd0);
                end else begin
                    m = mem_q.pop_front();
                    cur = m;
                    chk("mem_we", {31'd0, mem_we}, {31'd0, m.we});
                    chk("mem_addr", mem_addr, m.addr);
                    if (m.we) chk("mem_wdata", mem_wdata, m.wdata);
                end
            end else if (mem_req) begin
                chk("mem_addr_stable", mem_addr, cur.addr);
                chk("mem_we_stable", {31'd0, mem_we}, {31'd0, cur.we});
            end
            req_q = mem_req;
            if (i_ack || d_ack) begin
                if (ack_q.size() == 0) begin
                    chk("ack_unexpected", {30'd0, d_ack, i_ack}, 32'd0);
                end else begin
                    a = ack_q.pop_front();
                    chk("ack_is_d", {31'd0, d_ack}, {31'd0, a.is_d});
                    chk("ack_is_i", {31'd0, i_ack}, {31'd0, !a.is_d});
                    chk("ack_rdata", a.is_d ? d_rdata : i_rdata, a.rdata);
                end
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        Reset = 1'b1;
        i_req = 1'b0; d_req = 1'b0; d_we = 1'b0; mem_ready = 1'b0;
        i_addr = '0; d_addr = '0; d_wdata = '0; mem_rdata = '0;
        repeat (2) @(posedge CLK);
        #1;
        chk("rst_owner", {30'd0, owner}, 32'd0);
        chk("rst_mem_req", {31'd0, mem_req}, 32'd0);
        chk("rst_acks", {30'd0, d_ack, i_ack}, 32'd0);
        chk("rst_i_rdata", i_rdata, 32'd0);
        chk("rst_d_rdata", d_rdata, 32'd0);
        Reset = 1'b0;
        step();

        // I read, ready two cycles after mem_req
        i_req = 1'b1; i_addr = 32'h100;
        push_exp(1'b0, 1'b0, 32'h100, 32'h0, 32'hE3A01005);
        chk("req_cycle0_no_mem_req", {31'd0, mem_req}, 32'd0);
        step();
        serve(1'b0, 2, 32'hE3A01005);
        i_req = 1'b0;
        step();
        chk("i_ack_single", {31'd0, i_ack}, 32'd0);
        chk("idle_owner", {30'd0, owner}, 32'd0);

        // D read to give d_rdata a known value
        d_req = 1'b1; d_we = 1'b0; d_addr = 32'h2000;
        push_exp(1'b1, 1'b0, 32'h2000, 32'h0, 32'h12345678);
        step();
        serve(1'b1, 1, 32'h12345678);
        d_req = 1'b0;
        step();

        // D write: d_rdata must keep the previous refill value
        d_req = 1'b1; d_we = 1'b1; d_addr = 32'h2000; d_wdata = 32'hDEADBEEF;
        push_exp(1'b1, 1'b1, 32'h2000, 32'hDEADBEEF, 32'h12345678);
        step();
        serve(1'b1, 0, 32'h5A5A5A5A);
        d_req = 1'b0; d_we = 1'b0;
        step();
        chk("d_rdata_after_write", d_rdata, 32'h12345678);

        // Simultaneous requests: D first, then I
        i_req = 1'b1; i_addr = 32'h140;
        d_req = 1'b1; d_addr = 32'h2100;
        push_exp(1'b1, 1'b0, 32'h2100, 32'h0, 32'hAAAA5555);
        push_exp(1'b0, 1'b0, 32'h140, 32'h0, 32'h0BADF00D);
        step();
        serve(1'b1, 1, 32'hAAAA5555);
        d_req = 1'b0;
        step();
        chk("tie_idle_between", {30'd0, owner}, 32'd0);
        step();
        serve(1'b0, 0, 32'h0BADF00D);
        i_req = 1'b0;
        step();

        // mem_ready in IDLE is ignored
        mem_ready = 1'b1; mem_rdata = 32'h55555555;
        step();
        step();
        mem_ready = 1'b0;
        chk("idle_ready_owner", {30'd0, owner}, 32'd0);
        chk("idle_ready_mem_req", {31'd0, mem_req}, 32'd0);
        chk("idle_ready_i_rdata", i_rdata, 32'h0BADF00D);
        chk("idle_ready_d_rdata", d_rdata, 32'hAAAA5555);

        // Reset the cycle after mem_req rises; no ack may follow
        i_req = 1'b1; i_addr = 32'h300;
        begin
            mem_exp_t m;
            m.we = 1'b0; m.addr = 32'h300; m.wdata = '0;
            mem_q.push_back(m);
        end
        step();
        chk("rst_flight_mem_req", {31'd0, mem_req}, 32'd1);
        step();
        Reset = 1'b1; mem_ready = 1'b1; mem_rdata = 32'h99999999;
        #1;
        chk("rst_async_mem_req", {31'd0, mem_req}, 32'd0);
        chk("rst_async_owner", {30'd0, owner}, 32'd0);
        chk("rst_async_i_rdata", i_rdata, 32'd0);
        step();
        Reset = 1'b0; i_req = 1'b0;
        step();
        mem_ready = 1'b0;
        chk("rst_no_ack", {30'd0, d_ack, i_ack}, 32'd0);
        chk("rst_idle_owner", {30'd0, owner}, 32'd0);
        chk("rst_i_rdata_clear", i_rdata, 32'd0);

        // Normal service after reset
        i_req = 1'b1; i_addr = 32'h104;
        push_exp(1'b0, 1'b0, 32'h104, 32'h0, 32'h600D600D);
        step();
        serve(1'b0, 0, 32'h600D600D);
        i_req = 1'b0;
        step();

`ifdef MEM_ARB_AGING_EN
        // Both held: three D transfers saturate the count, then I takes over
        i_req = 1'b1; i_addr = 32'h500;
        d_req = 1'b1; d_we = 1'b0; d_addr = 32'h4000;
        for (int k = 0; k < 3; k++)
            push_exp(1'b1, 1'b0, 32'h4000, 32'h0, 32'h11 + k);
        push_exp(1'b0, 1'b0, 32'h500, 32'h0, 32'h22);
        step();
        for (int k = 0; k < 3; k++) begin
            serve(1'b1, 0, 32'h11 + k);
            step();
            step();
        end
        serve(1'b0, 0, 32'h22);
        i_req = 1'b0; d_req = 1'b0;
        step();
`endif

        step();
        chk("mem_q_drained", mem_q.size(), 32'd0);
        chk("ack_q_drained", ack_q.size(), 32'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
